// File: rtl/rps_pkg.sv
// Shared constants for the stone/paper/scissors match scorer:
// result codes from the round judge, FSM state encoding and winner codes.
package rps_pkg;

   // Round result codes produced by the judge
   localparam logic [7:0] RES_TIE = 8'd0;
   localparam logic [7:0] RES_P1  = 8'd49;
   localparam logic [7:0] RES_P2  = 8'd50;
   localparam logic [7:0] RES_INV = 8'd63;

   // Scorer FSM state encoding
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] PLAY = 2'd1;
   localparam logic [1:0] OVER = 2'd2;

   // match_winner encoding
   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

endpackage

// File: rtl/rps_sat_counter.sv
// Saturating up-counter with synchronous clear; en freezes the count entirely.
module rps_sat_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Clear has priority over increment; increments stop at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (en) begin
         if (clr) begin
            count <= '0;
         end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
         end
      end
   end

endmodule

// File: rtl/rps_match_scorer.sv
// First-to-WIN_TARGET match scorer fed by the round judge over valid/ready.
// Optional feature macro: RPS_TIE_LIMIT_EN -- MAX_TIES consecutive accepted
// ties end the match as a draw (MAX_TIES exists only in that build).
module rps_match_scorer
   import rps_pkg::*;
#(
   parameter int unsigned WIN_TARGET = 3,
   parameter int unsigned SCORE_W    = 4
`ifdef RPS_TIE_LIMIT_EN
   ,
   parameter int unsigned MAX_TIES   = 5
`endif
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               start,
   input  logic               res_valid,
   input  logic [7:0]         res_code,
   output logic               res_ready,
   output logic [SCORE_W-1:0] p1_score,
   output logic [SCORE_W-1:0] p2_score,
   output logic [SCORE_W-1:0] inv_cnt,
   output logic               match_over,
   output logic [1:0]         match_winner
);

   logic [1:0] state_q;
   logic [1:0] state_d;
   logic       over_d;
   logic [1:0] winner_d;
   logic       accept;
   logic       take;
   logic       code_tie;
   logic       code_p1;
   logic       code_p2;
   logic       code_inv;
   logic       p1_win;
   logic       p2_win;
   logic       tie_end;

   // Ready is combinational on state and ena; upstream sees it in the same cycle
   assign res_ready = ena & (state_q == PLAY);
   assign accept    = res_valid & res_ready;
   // A start in the same cycle drops the result
   assign take      = accept & ~start;

   assign code_tie = (res_code == RES_TIE);
   assign code_p1  = (res_code == RES_P1);
   assign code_p2  = (res_code == RES_P2);
   // '?' and every unrecognised code count as invalid
   assign code_inv = (res_code == RES_INV) | ~(code_tie | code_p1 | code_p2);

   // The increment that reaches WIN_TARGET decides the match on the same edge
   assign p1_win = take & code_p1 & (p1_score == SCORE_W'(WIN_TARGET - 1));
   assign p2_win = take & code_p2 & (p2_score == SCORE_W'(WIN_TARGET - 1));

`ifdef RPS_TIE_LIMIT_EN
   localparam int unsigned TIE_W = $clog2(MAX_TIES + 1);
   logic [TIE_W-1:0] tie_run;

   // Run of consecutive accepted ties; any non-tie accept breaks the run
   rps_sat_counter #(.W(TIE_W)) u_tie_run (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (ena),
      .clr   (start | (accept & ~code_tie)),
      .inc   (take & code_tie),
      .count (tie_run)
   );

   assign tie_end = take & code_tie & (tie_run == TIE_W'(MAX_TIES - 1));
`else
   assign tie_end = 1'b0;
`endif

   rps_sat_counter #(.W(SCORE_W)) u_p1_score (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (ena),
      .clr   (start),
      .inc   (take & code_p1),
      .count (p1_score)
   );

   rps_sat_counter #(.W(SCORE_W)) u_p2_score (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (ena),
      .clr   (start),
      .inc   (take & code_p2),
      .count (p2_score)
   );

   rps_sat_counter #(.W(SCORE_W)) u_inv_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (ena),
      .clr   (start),
      .inc   (take & code_inv),
      .count (inv_cnt)
   );

   // Next state and next match result
   always_comb begin
      state_d  = state_q;
      over_d   = match_over;
      winner_d = match_winner;
      case (state_q)
         IDLE, OVER: begin
            if (start) begin
               state_d  = PLAY;
               over_d   = 1'b0;
               winner_d = WIN_NONE;
            end
         end
         PLAY: begin
            if (start) begin
               over_d   = 1'b0;
               winner_d = WIN_NONE;
            end else if (p1_win) begin
               state_d  = OVER;
               over_d   = 1'b1;
               winner_d = WIN_P1;
            end else if (p2_win) begin
               state_d  = OVER;
               over_d   = 1'b1;
               winner_d = WIN_P2;
            end else if (tie_end) begin
               state_d  = OVER;
               over_d   = 1'b1;
               winner_d = WIN_DRAW;
            end
         end
         default: begin
            state_d  = IDLE;
            over_d   = 1'b0;
            winner_d = WIN_NONE;
         end
      endcase
   end

   // State and match result registers, frozen while ena is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         match_over   <= 1'b0;
         match_winner <= WIN_NONE;
      end else if (ena) begin
         state_q      <= state_d;
         match_over   <= over_d;
         match_winner <= winner_d;
      end
   end

endmodule

// File: tb/tb_rps_match_scorer.sv
// Scoreboard bench for rps_match_scorer: the driver updates a behavioural
// match model and queues the expected post-edge outputs; the monitor pops and
// compares one entry after every clock edge. Honours RPS_TIE_LIMIT_EN.
module tb_rps_match_scorer;

   localparam int WIN_TARGET = 3;
   localparam int SCORE_W    = 4;
   localparam int MAX_TIES   = 5;
   localparam int INV_MAX    = (1 << SCORE_W) - 1;

   logic               clk       = 1'b0;
   logic               rst_n     = 1'b0;
   logic               ena       = 1'b0;
   logic               start     = 1'b0;
   logic               res_valid = 1'b0;
   logic [7:0]         res_code  = 8'd0;
   logic               res_ready;
   logic [SCORE_W-1:0] p1_score;
   logic [SCORE_W-1:0] p2_score;
   logic [SCORE_W-1:0] inv_cnt;
   logic               match_over;
   logic [1:0]         match_winner;

   always #5 clk = ~clk;

   rps_match_scorer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .start        (start),
      .res_valid    (res_valid),
      .res_code     (res_code),
      .res_ready    (res_ready),
      .p1_score     (p1_score),
      .p2_score     (p2_score),
      .inv_cnt      (inv_cnt),
      .match_over   (match_over),
      .match_winner (match_winner)
   );

   typedef struct {
      int    p1;
      int    p2;
      int    inv;
      bit    over;
      int    win;
      bit    rdy;
      string tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Behavioural match model: scores as integers, a "playing" flag, a tie run
   int m_p1, m_p2, m_inv, m_ties, m_win;
   bit m_over, m_play;

   function automatic void model_reset();
      m_p1 = 0; m_p2 = 0; m_inv = 0; m_ties = 0; m_win = 0;
      m_over = 1'b0; m_play = 1'b0;
   endfunction

   function automatic void model_decide(input int w);
      m_over = 1'b1;
      m_win  = w;
      m_play = 1'b0;
   endfunction

   function automatic void model_step(input bit e, input bit s, input bit v, input logic [7:0] c);
      bit acc;
      acc = e && m_play && v;
      if (!e) return;
      if (s) begin
         model_reset();
         m_play = 1'b1;
      end else if (acc) begin
         if (c == 8'd49) begin
            m_p1++;
            m_ties = 0;
            if (m_p1 == WIN_TARGET) model_decide(1);
         end else if (c == 8'd50) begin
            m_p2++;
            m_ties = 0;
            if (m_p2 == WIN_TARGET) model_decide(2);
         end else if (c == 8'd0) begin
            m_ties++;
`ifdef RPS_TIE_LIMIT_EN
            if (m_ties == MAX_TIES) model_decide(3);
`endif
         end else begin
            if (m_inv < INV_MAX) m_inv++;
            m_ties = 0;
         end
      end
   endfunction

   function automatic void push(input string tag, input bit e_now);
      exp_t ex;
      ex.p1 = m_p1; ex.p2 = m_p2; ex.inv = m_inv;
      ex.over = m_over; ex.win = m_win;
      ex.rdy = m_play && e_now;
      ex.tag = tag;
      exp_q.push_back(ex);
   endfunction

   task automatic step(input bit e, input bit s, input bit v, input logic [7:0] c, input string tag);
      @(negedge clk);
      ena = e; start = s; res_valid = v; res_code = c;
      model_step(e, s, v, c);
      push(tag, e);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b0; ena = 1'b0; start = 1'b0; res_valid = 1'b0; res_code = 8'd0;
      model_reset();
      push(tag, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: compare every queued expectation just after the clock edge
   always @(posedge clk) begin
      exp_t ex;
      #1;
      if (exp_q.size() > 0) begin
         ex = exp_q.pop_front();
         n_tests++;
         if (int'(p1_score) != ex.p1 || int'(p2_score) != ex.p2 || int'(inv_cnt) != ex.inv ||
             match_over != ex.over || int'(match_winner) != ex.win || res_ready != ex.rdy) begin
            n_fail++;
            $display("FAIL %s: got p1=%0d p2=%0d inv=%0d over=%0b win=%0d rdy=%0b, expected p1=%0d p2=%0d inv=%0d over=%0b win=%0d rdy=%0b",
                     ex.tag, p1_score, p2_score, inv_cnt, match_over, match_winner, res_ready,
                     ex.p1, ex.p2, ex.inv, ex.over, ex.win, ex.rdy);
         end
      end
   end

   initial begin
      logic [7:0] c;
      int         r;
      model_reset();

      do_reset("reset");
      step(1, 0, 0, 8'd0, "idle_after_reset");
      step(1, 0, 1, 8'd49, "idle_ignores_valid");

      // P1 takes the match 3-1
      step(1, 1, 0, 8'd0, "t1_start");
      step(1, 0, 1, 8'd49, "t1_p1_a");
      step(1, 0, 1, 8'd50, "t1_p2");
      step(1, 0, 1, 8'd49, "t1_p1_b");
      step(1, 0, 1, 8'd49, "t1_p1_win");
      step(1, 0, 1, 8'd50, "t1_over_hold_a");
      step(1, 0, 1, 8'd49, "t1_over_hold_b");

      // Tie and invalid codes only
      step(1, 1, 0, 8'd0, "t2_start");
      step(1, 0, 1, 8'd0, "t2_tie");
      step(1, 0, 1, 8'd63, "t2_inv_q");
      step(1, 0, 1, 8'hAA, "t2_inv_aa");

      // start beats a simultaneous accept; ena low freezes everything
      step(1, 1, 1, 8'd49, "t3_start_drops");
      step(1, 0, 1, 8'd49, "t3_p1");
      step(0, 0, 1, 8'd49, "t3_frozen_a");
      step(0, 1, 1, 8'd50, "t3_frozen_b");
      step(0, 0, 1, 8'd63, "t3_frozen_c");
      step(1, 0, 0, 8'd0, "t3_resume");

      // P2 wins, results in OVER are ignored, start reopens play
      step(1, 1, 0, 8'd0, "t4_start");
      for (int i = 0; i < 3; i++) step(1, 0, 1, 8'd50, "t4_p2");
      for (int i = 0; i < 4; i++) step(1, 0, 1, 8'd50, "t4_over_ignore");
      step(1, 1, 0, 8'd0, "t4_restart");
      step(1, 0, 0, 8'd0, "t4_play_idle");

      // Reset mid-match with p1=2 discards the match
      step(1, 1, 0, 8'd0, "t5_start");
      step(1, 0, 1, 8'd49, "t5_p1_a");
      step(1, 0, 1, 8'd49, "t5_p1_b");
      do_reset("t5_mid_reset");
      step(1, 0, 0, 8'd0, "t5_idle");

      // inv_cnt saturation after 20 invalid codes
      step(1, 1, 0, 8'd0, "sat_start");
      for (int i = 0; i < 20; i++) begin
         c = (i % 2 == 0) ? 8'd63 : 8'(8'h80 + i);
         step(1, 0, 1, c, "sat_inv");
      end

      // Tie runs: 10 straight ties, then a run broken by a P1 win
      step(1, 1, 0, 8'd0, "t6_start");
      for (int i = 0; i < 10; i++) step(1, 0, 1, 8'd0, "t6_ties");
      step(1, 1, 0, 8'd0, "t6_restart");
      step(1, 0, 1, 8'd0, "t6_tie_a");
      step(1, 0, 1, 8'd0, "t6_tie_b");
      step(1, 0, 1, 8'd49, "t6_break");
      for (int i = 0; i < 4; i++) step(1, 0, 1, 8'd0, "t6_tie_run");

      // Randomised traffic
      for (int i = 0; i < 600; i++) begin
         r = int'($urandom_range(0, 4));
         case (r)
            0:       c = 8'd0;
            1:       c = 8'd49;
            2:       c = 8'd50;
            3:       c = 8'd63;
            default: c = 8'($urandom);
         endcase
         step(($urandom_range(0, 9) != 0), ($urandom_range(0, 24) == 0),
              1'($urandom_range(0, 1)), c, "rand");
      end

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
